// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: functional-unit result handshakes, flush and the broadcast CDB.
// master = functional-unit/pipeline side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int N_SRC    = 4,
  parameter int DATA_W   = 32,
  parameter int ROB_IX_W = 3,
  parameter int SRC_W    = $clog2(N_SRC)
);
  logic                       flush_in;
  logic [N_SRC-1:0]           valid_in;
  logic [N_SRC*DATA_W-1:0]    value_in;
  logic [N_SRC*ROB_IX_W-1:0]  rob_ix_in;
  logic [N_SRC-1:0]           read_out;
  logic                       cdb_valid_out;
  logic [DATA_W-1:0]          cdb_value_out;
  logic [ROB_IX_W-1:0]        cdb_rob_ix_out;
  logic [SRC_W-1:0]           cdb_src_out;

  modport master (
    output flush_in, valid_in, value_in, rob_ix_in,
    input  read_out, cdb_valid_out, cdb_value_out, cdb_rob_ix_out, cdb_src_out
  );

  modport slave (
    input  flush_in, valid_in, value_in, rob_ix_in,
    output read_out, cdb_valid_out, cdb_value_out, cdb_rob_ix_out, cdb_src_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a one-entry capture slot per functional unit; result on CDB the cycle after capture.
// Backpressure: read_out[i] drops only while slot i is full and not granted; independent of valid_in.
module cdb_arbiter #(
  parameter int N_SRC    = 4,
  parameter int DATA_W   = 32,
  parameter int ROB_IX_W = 3,
  parameter int SRC_W    = $clog2(N_SRC)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  cdb_arbiter_if.slave  bus
);

  logic [N_SRC-1:0]    slot_valid;
  logic [DATA_W-1:0]   slot_value [N_SRC];
  logic [ROB_IX_W-1:0] slot_rob_ix [N_SRC];
  logic [SRC_W-1:0]    rr_ptr;

  logic [N_SRC-1:0]    grant;
  logic                gnt_any;
  logic [SRC_W-1:0]    gnt_ix;
  logic [SRC_W-1:0]    next_ptr;
  logic                bcast;

  // Scan from rr_ptr upward (wrapping); first occupied slot wins.
  always_comb begin
    int idx;
    logic [SRC_W-1:0] idx_s;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_ix  = '0;
    idx     = 0;
    idx_s   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx   = (int'(rr_ptr) + k) % N_SRC;
      idx_s = idx[SRC_W-1:0];
      if (!gnt_any && slot_valid[idx_s]) begin
        gnt_any = 1'b1;
        gnt_ix  = idx_s;
      end
    end
    if (gnt_any) grant[gnt_ix] = 1'b1;
  end

  assign next_ptr = (gnt_ix == SRC_W'(N_SRC - 1)) ? '0 : gnt_ix + 1'b1;
  assign bcast    = gnt_any && !bus.flush_in;

  assign bus.read_out       = bus.flush_in ? {N_SRC{1'b1}} : (~slot_valid | grant);
  assign bus.cdb_valid_out  = bcast;
  assign bus.cdb_value_out  = bcast ? slot_value[gnt_ix]  : '0;
  assign bus.cdb_rob_ix_out = bcast ? slot_rob_ix[gnt_ix] : '0;
  assign bus.cdb_src_out    = bcast ? gnt_ix              : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
    end else if (bcast) begin
      rr_ptr <= next_ptr;
    end

    // Load takes precedence over grant-clear so a granted slot refills in the same edge.
    for (int i = 0; i < N_SRC; i++) begin
      if (rst_in || bus.flush_in) begin
        slot_valid[i] <= 1'b0;
      end else if (bus.valid_in[i] && bus.read_out[i]) begin
        slot_valid[i]  <= 1'b1;
        slot_value[i]  <= bus.value_in[i*DATA_W +: DATA_W];
        slot_rob_ix[i] <= bus.rob_ix_in[i*ROB_IX_W +: ROB_IX_W];
      end else if (grant[i]) begin
        slot_valid[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-cycle comparison against a behavioural slot/pointer model plus literal checkpoints.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(N), .DATA_W(DW), .ROB_IX_W(RW), .SRC_W(SW)) bus ();

  cdb_arbiter #(.N_SRC(N), .DATA_W(DW), .ROB_IX_W(RW), .SRC_W(SW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int total  = 0;
  int passed = 0;
  int cnt20  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Behavioural model: what each slot holds and where round-robin scanning starts.
  bit          m_full [N];
  logic [31:0] m_val  [N];
  logic [2:0]  m_rob  [N];
  int          m_ptr;
  bit          m_ok = 0;

  initial begin
    int       win;
    bit [3:0] exp_read;
    bit       exp_bc;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_val[i] = 0; m_rob[i] = 0;
    end
    m_ptr = 0;
    forever begin
      @(negedge clk);
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && m_full[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      exp_bc = (win >= 0) && !bus.flush_in;
      for (int i = 0; i < N; i++) exp_read[i] = bus.flush_in || !m_full[i] || (win == i);
      if (bus.cdb_valid_out === 1'b1 && bus.cdb_value_out === 32'd20) cnt20++;
      if (m_ok) begin
        check("read_out", 64'(bus.read_out), 64'(exp_read));
        check("cdb_valid", 64'(bus.cdb_valid_out), 64'(exp_bc));
        check("cdb_value", 64'(bus.cdb_value_out), exp_bc ? 64'(m_val[win]) : 64'd0);
        check("cdb_rob_ix", 64'(bus.cdb_rob_ix_out), exp_bc ? 64'(m_rob[win]) : 64'd0);
        check("cdb_src", 64'(bus.cdb_src_out), exp_bc ? 64'(win) : 64'd0);
        check("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
      end
      @(posedge clk);
      if (rst || bus.flush_in) begin
        for (int i = 0; i < N; i++) m_full[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (bus.valid_in[i] && exp_read[i]) begin
            m_full[i] = 1;
            m_val[i]  = bus.value_in[i*DW +: DW];
            m_rob[i]  = bus.rob_ix_in[i*RW +: RW];
          end else if (win == i) begin
            m_full[i] = 0;
          end
        end
      end
      if (rst) m_ptr = 0;
      else if (exp_bc) m_ptr = (win + 1) % N;
      if (rst) m_ok = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int src, input logic [31:0] val, input logic [2:0] rob);
    bus.valid_in[src]             = 1'b1;
    bus.value_in[src*DW +: DW]    = val;
    bus.rob_ix_in[src*RW +: RW]   = rob;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.flush_in = 1'b0;
    bus.valid_in = '0;
    bus.value_in = '0;
    bus.rob_ix_in = '0;
    #1;

    // Reset
    do_reset();
    @(negedge clk);
    check("rst_cdb_valid", 64'(bus.cdb_valid_out), 64'd0);
    check("rst_read_out", 64'(bus.read_out), 64'hF);
    check("rst_cdb_data", 64'({bus.cdb_value_out, bus.cdb_rob_ix_out, bus.cdb_src_out}), 64'd0);
    step();

    // Single source
    offer(0, 32'h0000_0007, 3'd3);
    step();
    bus.valid_in = '0;
    @(negedge clk);
    check("single_valid", 64'(bus.cdb_valid_out), 64'd1);
    check("single_value", 64'(bus.cdb_value_out), 64'd7);
    check("single_rob", 64'(bus.cdb_rob_ix_out), 64'd3);
    check("single_src", 64'(bus.cdb_src_out), 64'd0);
    step();
    @(negedge clk);
    check("single_after", 64'(bus.cdb_valid_out), 64'd0);

    // Contention, from a freshly reset pointer
    do_reset();
    for (int s = 0; s < N; s++) offer(s, 32'(10 + s), 3'(s));
    step();
    bus.valid_in = '0;
    for (int s = 0; s < N; s++) begin
      @(negedge clk);
      check("cont_src", 64'(bus.cdb_src_out), 64'(s));
      check("cont_value", 64'(bus.cdb_value_out), 64'(10 + s));
      step();
    end
    @(negedge clk);
    check("cont_ptr", 64'(dut.rr_ptr), 64'd0);
    check("cont_idle", 64'(bus.cdb_valid_out), 64'd0);

    // Backpressure: slots 0 and 1 full, source 1 keeps offering 20
    offer(0, 32'd30, 3'd4);
    offer(1, 32'd21, 3'd5);
    step();
    bus.valid_in[0] = 1'b0;
    offer(1, 32'd20, 3'd6);
    @(negedge clk);
    check("bp_read1_low", 64'(bus.read_out[1]), 64'd0);
    check("bp_first", 64'(bus.cdb_value_out), 64'd30);
    step();
    @(negedge clk);
    check("bp_read1_high", 64'(bus.read_out[1]), 64'd1);
    check("bp_second", 64'(bus.cdb_value_out), 64'd21);
    step();
    bus.valid_in = '0;
    @(negedge clk);
    check("bp_held_value", 64'(bus.cdb_value_out), 64'd20);
    check("bp_held_src", 64'(bus.cdb_src_out), 64'd1);
    step();

    // Streaming from source 2
    offer(2, 32'd1, 3'd0);
    step();
    for (int k = 2; k <= 4; k++) begin
      offer(2, 32'(k), 3'(k - 1));
      @(negedge clk);
      check("stream_read2", 64'(bus.read_out[2]), 64'd1);
      check("stream_value", 64'(bus.cdb_value_out), 64'(k - 1));
      step();
    end
    bus.valid_in = '0;
    @(negedge clk);
    check("stream_last", 64'(bus.cdb_value_out), 64'd4);
    step();
    @(negedge clk);
    check("stream_idle", 64'(bus.cdb_valid_out), 64'd0);

    // Flush with slots 0 and 3 full, source 1 offering during the flush
    offer(0, 32'd40, 3'd1);
    offer(3, 32'd43, 3'd2);
    step();
    bus.valid_in = '0;
    bus.flush_in = 1'b1;
    offer(1, 32'd41, 3'd7);
    @(negedge clk);
    check("flush_valid", 64'(bus.cdb_valid_out), 64'd0);
    check("flush_read", 64'(bus.read_out), 64'hF);
    step();
    bus.flush_in = 1'b0;
    bus.valid_in = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_flush_valid", 64'(bus.cdb_valid_out), 64'd0);
      check("post_flush_read", 64'(bus.read_out), 64'hF);
      step();
    end

    check("value20_once", 64'(cnt20), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter sitting directly downstream of the functional units (alu, branch alu, mul, div) and upstream of the reorder buffer and reservation stations. Each functional unit hands its result over through a valid/read handshake into a one-entry capture slot. Each cycle the arbiter broadcasts at most one captured result on the CDB, chosen round-robin. The slots decouple functional-unit completion from bus contention, so a unit is freed as soon as its result is captured.

## Interface
- `N_SRC`, default 4: number of functional-unit sources; index 0 = alu, 1 = branch alu, 2 = mul, 3 = div.
- `DATA_W`, default 32: result width.
- `ROB_IX_W`, default 3: ROB index width (8-entry ROB).
- `SRC_W`, default $clog2(N_SRC): width of the source id.

Ports:
- `clk_in` in 1: single clock; all state updates on its rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `flush_in` in 1: synchronous squash of all captured, unbroadcast results.
- `valid_in` in N_SRC: bit i high = source i presents a result this cycle.
- `value_in` in N_SRC*DATA_W: source i result, bits [i*DATA_W +: DATA_W].
- `rob_ix_in` in N_SRC*ROB_IX_W: source i ROB index, bits [i*ROB_IX_W +: ROB_IX_W].
- `read_out` out N_SRC: bit i high = the source i result is taken at this edge if `valid_in[i]` is high. This bit drives the functional unit's `read_in`.
- `cdb_valid_out` out 1: the broadcast is valid this cycle.
- `cdb_value_out` out DATA_W: broadcast result.
- `cdb_rob_ix_out` out ROB_IX_W: ROB index of the broadcast result.
- `cdb_src_out` out SRC_W: index of the winning source.

## Operation
- State:
  - per-source slot: `slot_valid[i]`, `slot_value[i]`, `slot_rob_ix[i]`;
  - round-robin pointer `rr_ptr` (SRC_W bits).
- Grant, combinational from registered state only:
  - Scan indices rr_ptr, rr_ptr+1, … mod N_SRC.
  - The first index with `slot_valid` set gets one-hot `grant`.
  - If no slot is valid, there is no grant.
- `read_out[i] = !slot_valid[i] || grant[i]` when flush_in is low, and 1 when flush_in is high.
  - `read_out` never depends on `valid_in`, so there is no combinational loop with the functional units.
- CDB drive:
  - `cdb_valid_out = |grant && !flush_in`.
  - value, rob_ix and src come from the granted slot.
  - All three are 0 when there is no grant or flush_in is high.
- Slot update at the edge, for each i, in priority order:
  1. rst_in or flush_in: slot cleared.
  2. Otherwise `valid_in[i] && read_out[i]`: slot loaded with the source i value and rob_ix, valid set. This covers a same-cycle drain and refill.
  3. Otherwise `grant[i]`: slot cleared.
  4. Otherwise the slot holds.
- Pointer update:
  - rst_in: rr_ptr = 0.
  - Else if a grant occurred and flush_in is low: rr_ptr = (granted index + 1) mod N_SRC.
  - Else rr_ptr is unchanged; flush does not move it.
- Fairness: a continuously occupied slot is broadcast within N_SRC cycles.
- Results are never dropped or duplicated except by flush or reset.

## Timing
- Reset values:
  - all slots empty, rr_ptr = 0;
  - `read_out` all ones, `cdb_valid_out` = 0;
  - `cdb_value_out`, `cdb_rob_ix_out`, `cdb_src_out` = 0.
- Latency: a result accepted at edge t (valid_in and read_out both high in cycle t-1) can appear on the CDB in cycle t at the earliest. Under contention it waits up to N_SRC-1 more cycles.
- Throughput:
  - one broadcast per cycle total;
  - one result per cycle per source, sustained, when that source always wins (the drain-and-refill path).
- Full slot that is not granted: `read_out[i] = 0`. The source must hold `valid_in` and its data stable until read_out is high.
- Reset mid-operation: slots cleared at that edge. Pending results are lost, no broadcast occurs in the reset cycle's successor, and `read_out` returns to all ones.
- Flush concurrent with a grant: no broadcast, and the granted result is discarded. Data offered in the flush cycle is consumed (read_out = 1) and discarded.

## Test plan
- Reset: assert rst_in for 2 cycles, then release with valid_in = 0.
  - Expect cdb_valid_out = 0, read_out = 4'b1111, and all CDB data = 0.
- Single source: source 0 offers value 32'h0000_0007 with rob_ix 3 for one cycle.
  - Expect the next cycle: cdb_valid_out = 1, value = 7, rob_ix = 3, src = 0.
  - Expect the cycle after: cdb_valid_out = 0.
- Contention: all four sources offer values 10, 11, 12, 13 (rob_ix 0..3) in the same cycle, then drop valid.
  - Expect broadcasts on four consecutive cycles in order src 0, 1, 2, 3.
  - Expect rr_ptr = 0 afterwards.
- Backpressure: source 1 holds valid with value 20 while sources 0 and 1 both hold occupied slots and rr_ptr = 0.
  - Expect read_out[1] = 0 until slot 1 is granted.
  - Expect no value lost, and value 20 broadcast exactly once.
- Streaming: source 2 alone offers values 1, 2, 3, 4 on consecutive cycles.
  - Expect read_out[2] to stay high throughout.
  - Expect CDB values 1, 2, 3, 4 on consecutive cycles, each one cycle after its offer.
- Flush: fill slots 0 and 3, then assert flush_in for one cycle.
  - Expect cdb_valid_out = 0 during the flush cycle and after it.
  - Expect read_out = 4'b1111 afterwards, and no stale broadcast later.
